// File: rtl/llpage_pkg.sv
// Shared types and helpers for the linked-list page client: requester state
// encoding plus popcount / lowest-set-bit helpers used by the arbiters.
package llpage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } req_state_e;

  // Helpers operate on a fixed 32-bit vector; callers size-cast in and out.
  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] lowest_onehot(input logic [FN_W-1:0] v);
    return v & (~v + FN_W'(1));
  endfunction

  function automatic logic [5:0] popcount(input logic [FN_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < FN_W; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/llpage_req.sv
// Per-source page requester: registered request held until ack, then an
// optional idle gap of exactly cfg_gap cycles before the next request.
//
// state | meaning
// IDLE  | waiting for start (grant with enable and credit)
// REQ   | o_req held high until ack is sampled
// GAP   | counting down cfg_gap idle cycles after the ack
module llpage_req
  import llpage_pkg::*;
#(
  parameter int gap_width = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [gap_width-1:0] i_cfg_gap,
  input  logic                 i_ack,
  output logic                 o_req,
  output logic                 o_in_req,
  output logic                 o_idle
);

  req_state_e           r_state;
  logic [gap_width-1:0] r_gap_cnt;
  logic                 r_req;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
      r_req     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (i_ack) begin
            r_req <= 1'b0;
            if (i_cfg_gap != '0) begin
              r_state   <= GAP;
              r_gap_cnt <= i_cfg_gap;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt <= gap_width'(1)) r_state <= IDLE;
          else r_gap_cnt <= r_gap_cnt - gap_width'(1);
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req    = r_req;
  assign o_in_req = (r_state == REQ);
  assign o_idle   = (r_state == IDLE);

endmodule

// File: rtl/llpage_client.sv
// Page-client traffic model: credit-limited per-source requesters, a hold FIFO
// for returned pages, and round-robin reclaim into per-sink holding registers.
module llpage_client
  import llpage_pkg::*;
#(
  parameter int lpsz       = 8,
  parameter int sources    = 4,
  parameter int sinks      = 4,
  parameter int hold_depth = 16,
  parameter int gap_width  = 8,
  parameter int cnt_width  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [gap_width-1:0]    i_cfg_gap,
  input  logic [cnt_width-1:0]    i_cfg_max_pages,
  output logic [sources-1:0]      o_pgreq,
  input  logic [sources-1:0]      i_pgack,
  input  logic [sources-1:0]      i_lprq_srdy,
  output logic [sources-1:0]      o_lprq_drdy,
  input  logic [lpsz-1:0]         i_lprq_page,
  output logic [sinks-1:0]        o_lprt_srdy,
  input  logic [sinks-1:0]        i_lprt_drdy,
  output logic [sinks*lpsz-1:0]   o_lprt_page_list,
  output logic [cnt_width-1:0]    o_outstanding,
  output logic [cnt_width-1:0]    o_reclaimed_total
);

  localparam int AW  = $clog2(hold_depth);
  localparam int AW1 = AW + 1;
  localparam int RRW = (sinks > 1) ? $clog2(sinks) : 1;
  localparam int CW1 = cnt_width + 1;

  logic [sources-1:0]  w_in_req, w_idle, w_elig, w_start, w_ack;
  logic [CW1-1:0]      w_demand, w_out_up, w_recl;
  logic                w_credit_ok;
  logic [sinks-1:0]    w_avail, w_hs;
  logic [RRW-1:0]      w_sel, w_cand, w_rr_nxt;
  logic                w_found, w_pop, w_push, w_full, w_empty;

  logic [lpsz-1:0]       r_mem [hold_depth];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;
  logic [RRW-1:0]        r_rr;
  logic [sinks-1:0]      r_lprt_srdy;
  logic [sinks*lpsz-1:0] r_page_list;
  logic [cnt_width-1:0]  r_outstanding, r_total;

  for (genvar g = 0; g < sources; g++) begin : g_req
    llpage_req #(.gap_width(gap_width)) u_req (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (w_start[g]),
      .i_cfg_gap (i_cfg_gap),
      .i_ack     (i_pgack[g]),
      .o_req     (o_pgreq[g]),
      .o_in_req  (w_in_req[g]),
      .o_idle    (w_idle[g])
    );
  end

  // Pages already granted but not yet acked count against the credit limit.
  assign w_demand    = CW1'(r_outstanding) + CW1'(popcount(FN_W'(w_in_req)));
  assign w_credit_ok = w_demand < CW1'(i_cfg_max_pages);
  assign w_elig      = w_idle & {sources{i_enable & w_credit_ok}};
  assign w_start     = sources'(lowest_onehot(FN_W'(w_elig)));
  assign w_ack       = i_pgack & w_in_req;

  assign w_full      = (r_count == AW1'(hold_depth));
  assign w_empty     = (r_count == '0);
  assign o_lprq_drdy = w_full ? '0 : sources'(lowest_onehot(FN_W'(i_lprq_srdy)));
  assign w_push      = |(i_lprq_srdy & o_lprq_drdy);

  // A sink can take the head if its register is empty or drains this cycle.
  always_comb begin
    w_avail = ~r_lprt_srdy | i_lprt_drdy;
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < sinks; k++) begin
      w_cand = RRW'((int'(r_rr) + k) % sinks);
      if (!w_found && w_avail[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_pop    = w_found & ~w_empty;
  assign w_rr_nxt = (w_sel == RRW'(sinks - 1)) ? '0 : w_sel + RRW'(1);
  assign w_hs     = r_lprt_srdy & i_lprt_drdy;
  assign w_out_up = CW1'(r_outstanding) + CW1'(popcount(FN_W'(w_ack)));
  assign w_recl   = CW1'(popcount(FN_W'(w_hs)));

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_lprq_page;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rr          <= '0;
      r_lprt_srdy   <= '0;
      r_page_list   <= '0;
      r_outstanding <= '0;
      r_total       <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rr     <= w_rr_nxt;
      end
      if (w_push && !w_pop) r_count <= r_count + AW1'(1);
      else if (!w_push && w_pop) r_count <= r_count - AW1'(1);
      for (int i = 0; i < sinks; i++) begin
        if (w_pop && (w_sel == RRW'(i))) begin
          r_lprt_srdy[i]               <= 1'b1;
          r_page_list[i*lpsz +: lpsz]  <= r_mem[r_rd_ptr];
        end else if (w_hs[i]) begin
          r_lprt_srdy[i] <= 1'b0;
        end
      end
      // Reclaims of pages never counted floor at zero rather than wrapping.
      r_outstanding <= (w_out_up < w_recl) ? '0 : cnt_width'(w_out_up - w_recl);
      r_total       <= r_total + cnt_width'(w_recl);
    end
  end

  assign o_lprt_srdy       = r_lprt_srdy;
  assign o_lprt_page_list  = r_page_list;
  assign o_outstanding     = r_outstanding;
  assign o_reclaimed_total = r_total;

endmodule

// File: tb/tb_llpage_client.sv
// Bench for llpage_client: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_llpage_client;

  localparam int LPSZ = 8, SRC = 4, SNK = 4, DEPTH = 16, GW = 8, CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, enable;
  logic [GW-1:0]        cfg_gap;
  logic [CW-1:0]        cfg_max;
  logic [SRC-1:0]       pgreq, pgack, lprq_srdy, lprq_drdy;
  logic [LPSZ-1:0]      lprq_page;
  logic [SNK-1:0]       lprt_srdy, lprt_drdy;
  logic [SNK*LPSZ-1:0]  page_list;
  logic [CW-1:0]        outstanding, total;

  llpage_client #(
    .lpsz(LPSZ), .sources(SRC), .sinks(SNK), .hold_depth(DEPTH),
    .gap_width(GW), .cnt_width(CW)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_enable          (enable),
    .i_cfg_gap         (cfg_gap),
    .i_cfg_max_pages   (cfg_max),
    .o_pgreq           (pgreq),
    .i_pgack           (pgack),
    .i_lprq_srdy       (lprq_srdy),
    .o_lprq_drdy       (lprq_drdy),
    .i_lprq_page       (lprq_page),
    .o_lprt_srdy       (lprt_srdy),
    .i_lprt_drdy       (lprt_drdy),
    .o_lprt_page_list  (page_list),
    .o_outstanding     (outstanding),
    .o_reclaimed_total (total)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: requester = (requesting flag, gap cycles left),
  // FIFO = queue, sinks = valid/data arrays, rr = next sink to try.
  bit            m_req [SRC];
  int            m_gap [SRC];
  int            m_out, m_total, pushes, ack_total;
  logic [7:0]    m_fifo [$];
  bit            m_sv [SNK];
  logic [7:0]    m_sd [SNK];
  int            m_rr;

  function automatic logic [SRC-1:0] m_pgreq();
    logic [SRC-1:0] r;
    for (int i = 0; i < SRC; i++) r[i] = m_req[i];
    return r;
  endfunction

  function automatic logic [SNK-1:0] m_srdy();
    logic [SNK-1:0] r;
    for (int i = 0; i < SNK; i++) r[i] = m_sv[i];
    return r;
  endfunction

  function automatic logic [SRC-1:0] m_drdy(input logic [SRC-1:0] s);
    logic [SRC-1:0] r;
    bit found;
    r = '0;
    found = 0;
    if (m_fifo.size() < DEPTH)
      for (int i = 0; i < SRC; i++)
        if (s[i] && !found) begin r[i] = 1'b1; found = 1; end
    return r;
  endfunction

  // Observation state for directed scenarios.
  int  cyc = 0;
  bit  gap_rec = 0, rec_en = 0, prev0 = 0;
  int  lowrun = 0;
  int  rise_t [$];
  int  lows [$];
  int  rec_sink [$];
  logic [7:0] rec_data [$];

  always @(negedge clk) begin
    logic [SRC-1:0] e_drdy;
    logic [SNK-1:0] hs;
    int grant, sel, n_req, n_ack, n_hs, j;
    bit credit;

    e_drdy = m_drdy(lprq_srdy);
    check("pgreq", 32'(pgreq), 32'(m_pgreq()));
    check("lprq_drdy", 32'(lprq_drdy), 32'(e_drdy));
    check("lprt_srdy", 32'(lprt_srdy), 32'(m_srdy()));
    check("outstanding", 32'(outstanding), 32'(CW'(m_out)));
    check("reclaimed_total", 32'(total), 32'(CW'(m_total)));
    for (int k = 0; k < SNK; k++)
      if (m_sv[k]) check("lprt_page", 32'(page_list[k*LPSZ +: LPSZ]), 32'(m_sd[k]));

    if (rec_en)
      for (int k = 0; k < SNK; k++)
        if (lprt_srdy[k] && lprt_drdy[k]) begin
          rec_sink.push_back(k);
          rec_data.push_back(page_list[k*LPSZ +: LPSZ]);
        end
    if (gap_rec) begin
      if (pgreq[0] && !prev0) begin
        rise_t.push_back(cyc);
        lows.push_back(lowrun);
        lowrun = 0;
      end else if (!pgreq[0]) begin
        lowrun++;
      end
      prev0 = pgreq[0];
    end

    if (reset) begin
      for (int i = 0; i < SRC; i++) begin m_req[i] = 0; m_gap[i] = 0; end
      for (int i = 0; i < SNK; i++) begin m_sv[i] = 0; m_sd[i] = '0; end
      m_fifo.delete();
      m_out = 0; m_total = 0; m_rr = 0; pushes = 0; ack_total = 0;
    end else begin
      n_req = 0;
      for (int i = 0; i < SRC; i++) n_req += int'(m_req[i]);
      credit = (m_out + n_req) < int'(cfg_max);
      grant = -1;
      if (enable && credit)
        for (int i = 0; i < SRC; i++)
          if (grant < 0 && !m_req[i] && m_gap[i] == 0) grant = i;
      for (int k = 0; k < SNK; k++) hs[k] = m_sv[k] && lprt_drdy[k];
      sel = -1;
      if (m_fifo.size() > 0)
        for (int k = 0; k < SNK; k++) begin
          j = (m_rr + k) % SNK;
          if (sel < 0 && (!m_sv[j] || lprt_drdy[j])) sel = j;
        end
      n_ack = 0;
      for (int i = 0; i < SRC; i++) begin
        if (m_req[i]) begin
          if (pgack[i]) begin
            m_req[i] = 0;
            m_gap[i] = int'(cfg_gap);
            n_ack++;
          end
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
        end else if (grant == i) begin
          m_req[i] = 1;
        end
      end
      ack_total += n_ack;
      n_hs = $countones(hs);
      m_out = m_out + n_ack - n_hs;
      if (m_out < 0) m_out = 0;
      m_total = (m_total + n_hs) % 65536;
      for (int k = 0; k < SNK; k++) if (hs[k]) m_sv[k] = 0;
      if (sel >= 0) begin
        m_sv[sel] = 1;
        m_sd[sel] = m_fifo.pop_front();
        m_rr = (sel + 1) % SNK;
      end
      if (|e_drdy) begin
        m_fifo.push_back(lprq_page);
        pushes++;
      end
    end
    cyc++;
  end

  // Stimulus policy applied once per cycle just after the rising edge.
  int             ack_mode, srdy_mode, drdy_mode, push_limit, page_base;
  logic [SRC-1:0] srdy_fix;
  logic [SNK-1:0] drdy_fix;
  bit             rst_q;

  task automatic drive();
    reset = rst_q;
    for (int i = 0; i < SRC; i++) begin
      if (ack_mode == 1)      pgack[i] = m_req[i];
      else if (ack_mode == 2) pgack[i] = 1'($urandom);
      else                    pgack[i] = 1'b0;
    end
    if (pushes >= push_limit || srdy_mode == 0) lprq_srdy = '0;
    else if (srdy_mode == 1)                    lprq_srdy = srdy_fix;
    else                                        lprq_srdy = SRC'($urandom);
    lprq_page = (srdy_mode == 2) ? LPSZ'($urandom) : LPSZ'(page_base + pushes);
    lprt_drdy = (drdy_mode == 2) ? SNK'($urandom) : drdy_fix;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive();
      #1;
    end
  endtask

  task automatic quiet();
    enable = 0; ack_mode = 0; srdy_mode = 0; drdy_mode = 0;
    srdy_fix = '0; drdy_fix = '0; push_limit = 1000000; page_base = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_q = 1;
    tick(1);
    rst_q = 0;
    tick(1);
  endtask

  initial begin
    quiet();
    cfg_gap = '0; cfg_max = '0; rst_q = 1;
    drive();
    tick(2);
    rst_q = 0;
    tick(1);
    check("reset_pgreq", 32'(pgreq), 32'h0);
    check("reset_outstanding", 32'(outstanding), 32'h0);
    check("reset_lprt_srdy", 32'(lprt_srdy), 32'h0);

    // Gap timing: one-cycle requests separated by 4 low cycles.
    do_reset();
    enable = 1; cfg_gap = 3; cfg_max = 100; ack_mode = 1;
    prev0 = 0; lowrun = 0; gap_rec = 1;
    tick(30);
    gap_rec = 0;
    check("gap_rise_count", 32'(rise_t.size() >= 4), 32'h1);
    for (int k = 1; k < rise_t.size() && k < 5; k++) begin
      check("gap_period", 32'(rise_t[k] - rise_t[k-1]), 32'd5);
      check("gap_low_cycles", 32'(lows[k]), 32'd4);
    end

    // Credit limit of 2 with no reclaim, then reclaim and resume.
    do_reset();
    enable = 1; cfg_gap = 0; cfg_max = 2; ack_mode = 1;
    tick(20);
    check("credit_acks", 32'(ack_total), 32'd2);
    check("credit_outstanding", 32'(outstanding), 32'd2);
    check("credit_pgreq_blocked", 32'(pgreq), 32'h0);
    ack_mode = 0; srdy_mode = 1; srdy_fix = 4'b0001; push_limit = 2; drdy_fix = 4'hf;
    tick(15);
    check("credit_drained", 32'(outstanding), 32'd0);
    check("credit_resumed_pgreq", 32'(pgreq), 32'h3);
    check("credit_reclaimed", 32'(total), 32'd2);

    // Zero credit blocks every request.
    do_reset();
    enable = 1; cfg_max = 0; ack_mode = 1;
    tick(10);
    check("zero_credit_pgreq", 32'(pgreq), 32'h0);

    // Return arbitration picks the lowest set srdy.
    do_reset();
    srdy_mode = 1; srdy_fix = 4'b1010;
    tick(1);
    check("arb_first", 32'(lprq_drdy), 32'h2);
    srdy_fix = 4'b1000;
    tick(1);
    check("arb_second", 32'(lprq_drdy), 32'h8);

    // FIFO full: 16 held + 4 parked, then one push per freed slot.
    do_reset();
    srdy_mode = 1; srdy_fix = 4'b0001; drdy_fix = 4'h0;
    tick(30);
    check("full_pushes", 32'(pushes), 32'd20);
    check("full_drdy", 32'(lprq_drdy), 32'h0);
    check("full_sinks", 32'(lprt_srdy), 32'hf);
    drdy_fix = 4'b0001;
    tick(1);
    check("full_no_bypass", 32'(lprq_drdy), 32'h0);
    drdy_fix = 4'h0;
    tick(3);
    check("full_one_more", 32'(pushes), 32'd21);
    check("full_drdy_again", 32'(lprq_drdy), 32'h0);

    // Round-robin reclaim of 0x10..0x17.
    do_reset();
    srdy_mode = 1; srdy_fix = 4'b0001; push_limit = 8; page_base = 8'h10; drdy_fix = 4'hf;
    rec_sink.delete(); rec_data.delete(); rec_en = 1;
    tick(20);
    rec_en = 0;
    check("rr_count", 32'(rec_sink.size()), 32'd8);
    for (int k = 0; k < rec_sink.size() && k < 8; k++) begin
      check("rr_sink", 32'(rec_sink[k]), 32'(k % 4));
      check("rr_data", 32'(rec_data[k]), 32'(8'h10 + k));
    end
    check("rr_total", 32'(total), 32'd8);

    // Reset mid-operation discards held pages and open requests.
    do_reset();
    enable = 1; cfg_max = 100; cfg_gap = 0;
    srdy_mode = 1; srdy_fix = 4'b0001; push_limit = 9; page_base = 8'h40;
    tick(15);
    check("midrst_pgreq_before", 32'(pgreq), 32'hf);
    check("midrst_sinks_before", 32'(lprt_srdy), 32'hf);
    enable = 0; srdy_mode = 0;
    rst_q = 1;
    tick(1);
    rst_q = 0;
    tick(1);
    check("midrst_pgreq", 32'(pgreq), 32'h0);
    check("midrst_lprq_drdy", 32'(lprq_drdy), 32'h0);
    check("midrst_lprt_srdy", 32'(lprt_srdy), 32'h0);
    check("midrst_page_list", 32'(page_list), 32'h0);
    check("midrst_outstanding", 32'(outstanding), 32'h0);
    check("midrst_total", 32'(total), 32'h0);
    drdy_fix = 4'hf;
    tick(20);
    check("midrst_no_stale", 32'(total), 32'h0);
    check("midrst_sinks_idle", 32'(lprt_srdy), 32'h0);

    // Randomized soak against the model.
    do_reset();
    ack_mode = 2; srdy_mode = 2; drdy_mode = 2;
    for (int blk = 0; blk < 15; blk++) begin
      cfg_gap = GW'($urandom_range(4));
      cfg_max = CW'($urandom_range(10));
      enable  = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) begin
        rst_q = 1;
        tick(1);
        rst_q = 0;
      end
      tick(200);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/llpage_client.md
Name: llpage_client

Overview:
- Synthesizable, parametrised page-client traffic model for the linked-list page manager.
- Per-source page requesters use req/ack with a programmable inter-request gap and a global outstanding-page credit limit.
- Returned pages are accepted, buffered in a hold FIFO, then reclaimed to the sinks in round-robin order.
- Replaces fixed-timing, single-sink stub stimulus in manager testbenches and FPGA soak builds.

Parameters:
- lpsz, 8, page number width in bits.
- sources, 4, number of page-request channels.
- sinks, 4, number of reclaim channels.
- hold_depth, 16, hold FIFO entries; power of two, ≥2.
- gap_width, 8, width of the gap configuration field.
- cnt_width, 16, width of the credit limit and status counters.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- enable  input  1  allows new requests to start.
- cfg_gap  input  gap_width  idle cycles after each ack.
- cfg_max_pages  input  cnt_width  credit limit on outstanding pages.
- pgreq  output  sources  per-source page request.
- pgack  input  sources  per-source page acknowledge.
- lprq_srdy  input  sources  returned-page valid, per source.
- lprq_drdy  output  sources  returned-page accept, per source.
- lprq_page  input  lpsz  returned page number (shared bus).
- lprt_srdy  output  sinks  reclaim valid, per sink.
- lprt_drdy  input  sinks  reclaim ready, per sink.
- lprt_page_list  output  sinks*lpsz  reclaim data; sink i uses bits [i*lpsz +: lpsz].
- outstanding  output  cnt_width  pages acked but not yet reclaimed.
- reclaimed_total  output  cnt_width  total reclaim handshakes; wraps.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Cleared to 0: pgreq, lprq_drdy, lprt_srdy, lprt_page_list, outstanding, reclaimed_total, FIFO pointers and count.
  - rr pointer set to 0; all requester FSMs go to IDLE.
  - Reset asserted mid-operation discards all held pages and aborts open requests. pgreq is 0 in the first cycle after the reset edge.
- Requester FSM, one per source, states IDLE / REQ / GAP:
  - IDLE -> REQ when enable & credit_ok & grant_i; pgreq_i is registered and rises the next cycle.
  - REQ holds pgreq_i = 1 until pgack_i = 1 is sampled while pgreq_i = 1.
  - On ack: go to GAP if cfg_gap ≠ 0, loading gap_cnt = cfg_gap; otherwise go to IDLE.
  - GAP decrements gap_cnt each cycle and goes to IDLE when it reaches 1. It therefore lasts exactly cfg_gap cycles.
  - Deasserting enable never drops pgreq mid-REQ. The FSM finishes REQ/GAP, then stays in IDLE.
  - pgack_i while not in REQ is ignored.
- Credit:
  - credit_ok = (outstanding + number of requesters in REQ) < cfg_max_pages.
  - At most one IDLE->REQ transition per cycle: grant_i goes to the lowest-index eligible source.
  - cfg_max_pages = 0 blocks all requests.
- outstanding update, per cycle: +(number of acks this cycle) − (number of reclaim handshakes this cycle). It never underflows; a reclaim when outstanding = 0 leaves it at 0.
- Return path:
  - When the FIFO is not full, lprq_drdy is one-hot on the lowest-index set lprq_srdy bit. Otherwise it is all zero.
  - lprq_drdy is combinational from lprq_srdy and the registered FIFO count.
  - Push on |(lprq_srdy & lprq_drdy); the page is written at wr_ptr.
  - Full is computed from the registered count, with no bypass. A pop in the same cycle does not enable a push.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo hold_depth.
- Reclaim dispatch:
  - Each sink has an output holding register (lprt_srdy_i plus data). It clears on lprt_srdy_i & lprt_drdy_i.
  - Each cycle, if the FIFO is not empty, the head goes to the first sink at or after the rr pointer whose register is empty or draining this cycle.
  - rr then moves to chosen + 1, modulo sinks. If no sink is available, there is no pop.
  - Data appears with srdy one cycle after the pop. FIFO-to-sink latency is at least 1 cycle.
  - lprt_page_list data is stable while lprt_srdy_i = 1 and lprt_drdy_i = 0.
- reclaimed_total increments by the popcount of (lprt_srdy & lprt_drdy) each cycle.

Decomposition:
- Shared package llpage_pkg holds:
  - requester state encoding: IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2;
  - a popcount function;
  - a lowest-set-bit one-hot function, shared with the arbiter.
- One sub-module, llpage_req: the per-source FSM plus gap counter. Inputs: start, cfg_gap, ack. Outputs: req, in_req, idle. Instantiated sources times.
- The FIFO, rr dispatch and counters stay in the top module.

Test Plan:
- Gap timing: enable = 1, cfg_gap = 3, cfg_max_pages = 100, source 0 acks the cycle after pgreq rises. Expect the pgreq[0] rising edges to be exactly 5 cycles apart, and pgreq low for 4 cycles between requests.
- Credit limit: cfg_max_pages = 2, all sources ack at once, no reclaim (lprt_drdy = 0). Expect exactly 2 acks, then pgreq stays 0 and outstanding = 2. Raise lprt_drdy after 2 pages have returned: outstanding drops to 0 and requests resume.
- Return arbitration: lprq_srdy = 4'b1010 held. Expect lprq_drdy = 4'b0010 first. Deassert lprq_srdy[1]: next lprq_drdy = 4'b1000.
- FIFO full: hold_depth = 16, lprt_drdy = 0, stream 20 return pages. Expect 16 FIFO pushes plus 4 pages parked in the sink registers, then lprq_drdy = 0. Release one sink: exactly one further push, with no push in the same cycle as the freeing pop.
- Round-robin reclaim: pages 0x10..0x17 returned, all lprt_drdy = 1. Expect sinks 0,1,2,3,0,1,2,3 to receive 0x10..0x17 in order, and reclaimed_total = 8.
- Reset mid-operation: pgreq high and FIFO count 5, assert reset for one cycle. The cycle after the reset edge shows all outputs 0; no stale page is ever reclaimed afterwards.
